seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The parameter list SHALL be: WIDTH, 32, operand width; C is 2*WIDTH bits.
REQ-002 The clock port SHALL be: clk  in  1  single clock; all state updates on posedge.
REQ-003 The reset port SHALL be: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 The start port SHALL be: start  in  1  request; sampled only in IDLE.
REQ-005 The dividend port SHALL be: A  in  WIDTH  dividend.
REQ-006 The divisor port SHALL be: B  in  WIDTH  divisor.
REQ-007 The busy port SHALL be: busy  out  1  high from the cycle after start is accepted until done.
REQ-008 The done port SHALL be: done  out  1  one-cycle pulse; C is valid from this cycle on.
REQ-009 The result port SHALL be: C  out  2*WIDTH  {remainder, quotient}, i.e. HI = remainder, LO = quotient.
REQ-010 The div_by_zero port SHALL be: div_by_zero  out  1  high with done when B was 0; holds until the next accepted start.

Function
REQ-011 The FSM SHALL have the states IDLE, SETUP, ITER, FIX and DONE.
REQ-012 In IDLE, start=1 SHALL register A and B and go to SETUP; start while busy SHALL be ignored.
REQ-013 SETUP SHALL latch operand signs, take magnitudes, clear the partial remainder, and load the iteration counter with WIDTH.
REQ-014 ITER SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, using a WIDTH+1-bit subtract.
REQ-015 FIX SHALL negate the quotient when the operand signs differ, and negate the remainder when the dividend is negative.
REQ-016 FIX SHALL then register C, after which the FSM enters DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 Latency SHALL be: start sampled at edge 0, done high after edge WIDTH+3 (35 cycles at WIDTH=32).
REQ-019 A new start SHALL be accepted in the cycle after done, i.e. with no dead cycle beyond DONE.
REQ-020 Quotient SHALL truncate toward zero, and remainder SHALL take the sign of the dividend.
REQ-021 The identity A = Q*B + R SHALL hold modulo 2^WIDTH.
REQ-022 Divide by zero SHALL go SETUP->DONE without iterating; C = {A, all-ones}, div_by_zero=1, done after edge 2.
REQ-023 Most-negative / -1 SHALL produce Q = most-negative and R = 0 (wrap), with no flag.
REQ-024 C SHALL hold its last value until the FIX or divide-by-zero update of the next operation, including while busy.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, div_by_zero=0, C=0, and clear the counter and internal registers.
REQ-026 Reset mid-operation SHALL abandon the division, with no done pulse after release.
REQ-027 The first start SHALL be accepted no earlier than the first posedge with rst_n=1.

Configuration
REQ-028 With DIV_SIGNED_EN defined, the block SHALL use two's-complement signed operands per REQ-015, REQ-020 and REQ-023.
REQ-029 Without DIV_SIGNED_EN, operands SHALL be unsigned, SETUP SHALL skip magnitude conversion, and FIX SHALL only register C.
REQ-030 Latency SHALL be identical in both configurations.

Structure
REQ-031 The shared package SHALL hold the FSM state enum typedef (div_state_t) and the default width constant DIV_WIDTH=32.
REQ-032 One sub-module, div_step, SHALL be natural: a combinational single shift-subtract step that takes partial remainder, next dividend bit and divisor, and returns the new remainder and quotient bit.
REQ-033 The FSM, counter and sign handling SHALL stay in seq_divider.

Verification
REQ-034 Bench scenario: A=100, B=7 -> done at cycle 35, C=64'h00000002_0000000E, div_by_zero=0.
REQ-035 Bench scenario (signed): A=-100, B=7 -> C=64'hFFFFFFFE_FFFFFFF2; A=100, B=-7 -> C=64'h00000002_FFFFFFF2.
REQ-036 Bench scenario: A=5, B=0 -> done after edge 2, div_by_zero=1, C=64'h00000005_FFFFFFFF.
REQ-037 Bench scenario (signed): A=32'h80000000, B=32'hFFFFFFFF -> C=64'h00000000_80000000, div_by_zero=0.
REQ-038 Bench scenario: start pulsed again at cycle 10 of an operation -> ignored; single done at cycle 35 with the first result.
REQ-039 Bench scenario: rst_n low at cycle 20 -> busy=0 and C=0 immediately; no done pulse.
REQ-040 Bench scenario: after the reset-mid-operation case, a new start completes normally.

Source files
------------

// File: rtl/seq_divider_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seq_divider_pkg : shared state type and default width for seq_divider
// Rev 1.0
// ============================================================================
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// div_step : one combinational restoring shift-subtract step
// Rev 1.0
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};

  // rem_i < div_i keeps shifted < 2*div_i, so the top bit of diff is a clean borrow
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seq_divider : multi-cycle restoring divider, C = {remainder, quotient}.
// Define DIV_SIGNED_EN for two's-complement operands (default: unsigned).
// Rev 1.0
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               div_by_zero
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t         state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] c_q;
`ifdef DIV_SIGNED_EN
  logic               neg_quo_q;
  logic               neg_rem_q;
`endif

  logic [WIDTH-1:0]   rem_d;
  logic               qbit_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .div_i (b_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      c_q       <= '0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          rem_q <= '0;
          cnt_q <= CNT_INIT;
          if (b_q == '0) begin
            // a_q is still the raw dividend here, so the zero-divisor result uses it unmodified
            c_q     <= {a_q, {WIDTH{1'b1}}};
            dbz_q   <= 1'b1;
            state_q <= DONE;
          end else begin
`ifdef DIV_SIGNED_EN
            neg_quo_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            neg_rem_q <= a_q[WIDTH-1];
            quo_q     <= a_q[WIDTH-1] ? -a_q : a_q;
            b_q       <= b_q[WIDTH-1] ? -b_q : b_q;
`else
            quo_q     <= a_q;
`endif
            state_q <= ITER;
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= FIX;
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          c_q <= {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};
`else
          c_q <= {rem_q, quo_q};
`endif
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign C           = c_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for seq_divider: timeline model plus directed vectors.
module tb_seq_divider;

  localparam int W      = 32;
  localparam int LAT    = W + 3;
  localparam int LAT_DZ = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   A     = '0;
  logic [W-1:0]   B     = '0;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] C;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit             m_active    = 1'b0;
  int             m_acc       = 0;
  int             m_done_edge = 0;
  logic [2*W-1:0] m_new_c     = '0;
  bit             m_new_dbz   = 1'b0;
  logic [2*W-1:0] e_c         = '0;
  bit             e_busy      = 1'b0;
  bit             e_done      = 1'b0;
  bit             e_dbz       = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .C           (C),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_SIGNED_EN
    longint sa, sb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
`else
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timeline model: an accepted op finishes LAT (or LAT_DZ) edges later; C moves one edge before done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      e_c      = '0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_dbz    = 1'b0;
    end else begin
      cyc    = cyc + 1;
      e_done = m_active && (cyc == m_done_edge);
      if (m_active && cyc == m_done_edge - 1) begin
        e_c   = m_new_c;
        e_dbz = m_new_dbz;
      end
      e_busy = m_active && (cyc < m_done_edge);
      if (start && (!m_active || cyc > m_done_edge)) begin
        m_active    = 1'b1;
        m_acc       = cyc;
        m_done_edge = cyc + ((B == '0) ? LAT_DZ : LAT);
        m_new_c     = ref_div(A, B);
        m_new_dbz   = (B == '0);
        e_busy      = 1'b1;
        e_dbz       = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("done", {63'd0, done}, {63'd0, e_done});
    chk("busy", {63'd0, busy}, {63'd0, e_busy});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e_dbz});
    chk("C", C, e_c);
  end

  task automatic launch_now(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    launch_now(a, b);
  endtask

  task automatic wait_done(input int lat, input logic [63:0] exp_c, input bit exp_dbz, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk({nm, " done timeout"}, {63'd0, done}, 64'd1);
    end else begin
      chk({nm, " latency"}, 64'(cyc - m_acc), 64'(lat));
      chk({nm, " result"}, C, exp_c);
      chk({nm, " dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                     input logic [63:0] exp_c, input bit exp_dbz, input string nm);
    launch(a, b);
    wait_done(lat, exp_c, exp_dbz, nm);
  endtask

  int n_done;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset C", C, 64'd0);
    rst_n = 1'b1;

    run(32'd100, 32'd7, 35, 64'h00000002_0000000E, 1'b0, "100/7");
    run(32'd5, 32'd0, 2, 64'h00000005_FFFFFFFF, 1'b1, "5/0");
    repeat (3) @(negedge clk);
    chk("dbz hold", {63'd0, div_by_zero}, 64'd1);

`ifdef DIV_SIGNED_EN
    run(32'h80000000, 32'hFFFFFFFF, 35, 64'h00000000_80000000, 1'b0, "minneg/-1");
    run(-32'sd100, 32'd7, 35, 64'hFFFFFFFE_FFFFFFF2, 1'b0, "-100/7");
    run(32'd100, -32'sd7, 35, 64'h00000002_FFFFFFF2, 1'b0, "100/-7");
`else
    run(32'h80000000, 32'hFFFFFFFF, 35, 64'h80000000_00000000, 1'b0, "minneg/-1");
    run(-32'sd100, 32'd7, 35, 64'h00000002_24924916, 1'b0, "-100/7");
    run(32'd100, -32'sd7, 35, 64'h00000064_00000000, 1'b0, "100/-7");
`endif

    // Back-to-back: next start is driven in the very cycle done is high.
    run(32'd1000, 32'd33, 35, 64'h0000000A_0000001E, 1'b0, "1000/33");
    launch_now(32'hFFFFFFFF, 32'd16);
`ifdef DIV_SIGNED_EN
    wait_done(35, 64'hFFFFFFFF_00000000, 1'b0, "b2b -1/16");
`else
    wait_done(35, 64'h0000000F_0FFFFFFF, 1'b0, "b2b ffffffff/16");
`endif

    // Start pulsed while busy must be ignored.
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    launch_now(32'd9, 32'd3);
    wait_done(35, 64'h00000002_0000000E, 1'b0, "busy start");
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("extra done after ignored start", 64'(n_done), 64'd0);

    // Reset in the middle of an operation.
    launch(32'd1000, 32'd33);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst C", C, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("done after midrst", 64'(n_done), 64'd0);

    run(32'd100, 32'd7, 35, 64'h00000002_0000000E, 1'b0, "post-reset 100/7");
    run(-32'sd100, 32'd0, 2, 64'hFFFFFF9C_FFFFFFFF, 1'b1, "-100/0");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
